// File: rtl/ic_tile_mem_responder.sv
// rtl/ic_tile_mem_responder.sv - I-cache tile fetch responder: four 32-bit downstream reads per 16-byte tile.
// Optional one-entry tile buffer is enabled by defining IC_RESP_TILE_BUF_EN.
`timescale 1ns/1ps
module ic_tile_mem_responder #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [63:0]  memPcAddr,
  input  logic         memPcOE,
  output logic [127:0] memPcData,
  output logic [1:0]   memPcOK,
  output logic [31:0]  busAddr,
  output logic         busOE,
  input  logic [31:0]  busData,
  input  logic [1:0]   busOK
);
  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd1;
  localparam logic [1:0] UMEM_OK_OK    = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;
  localparam logic [7:0] TIMEOUT_LIM   = TIMEOUT_CYC[7:0];

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_FAULT} state_t;

  state_t       state_q, state_d;
  logic [27:0]  tag_q, tag_d;
  logic [1:0]   beat_q, beat_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [95:0]  lanes_q, lanes_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   ok_q, ok_d;
  logic         oe_q, oe_d;
  logic [31:0]  addr_q, addr_d;
  logic [27:0]  req_tag;
  logic         buf_hit, fill_done, fill_fault;
  logic         unused_addr_bits;

  assign req_tag          = memPcAddr[31:4];
  assign unused_addr_bits = ^{memPcAddr[63:32], memPcAddr[3:0]};

`ifdef IC_RESP_TILE_BUF_EN
  // The buffered tile data lives in data_q: it is only rewritten on fill or fault.
  logic        buf_vld_q, buf_vld_d;
  logic [27:0] buf_tag_q, buf_tag_d;

  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_tag_d = buf_tag_q;
    if (fill_fault) begin
      buf_vld_d = 1'b0;
    end else if (fill_done) begin
      buf_vld_d = 1'b1;
      buf_tag_d = tag_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_vld_q <= 1'b0;
      buf_tag_q <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_tag_q <= buf_tag_d;
    end
  end

  assign buf_hit = buf_vld_q && (buf_tag_q == req_tag);
`else
  logic unused_fill;
  assign buf_hit     = 1'b0;
  assign unused_fill = fill_done ^ fill_fault;
`endif

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    lanes_d    = lanes_q;
    data_d     = data_q;
    ok_d       = ok_q;
    oe_d       = 1'b0;
    fill_done  = 1'b0;
    fill_fault = 1'b0;
    case (state_q)
      S_IDLE: begin
        ok_d = UMEM_OK_READY;
        if (memPcOE) begin
          tag_d  = req_tag;
          beat_d = 2'd0;
          cnt_d  = 8'd0;
          if (buf_hit) begin
            state_d = S_DONE;
            ok_d    = UMEM_OK_OK;
          end else begin
            state_d = S_FETCH;
            ok_d    = UMEM_OK_HOLD;
            oe_d    = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (!memPcOE) begin
          state_d = S_IDLE;
          ok_d    = UMEM_OK_READY;
        end else if (busOK == UMEM_OK_OK) begin
          cnt_d = 8'd0;
          if (beat_q == 2'd3) begin
            state_d   = S_DONE;
            ok_d      = UMEM_OK_OK;
            data_d    = {busData, lanes_q};
            fill_done = 1'b1;
          end else begin
            case (beat_q)
              2'd0:    lanes_d[31:0]  = busData;
              2'd1:    lanes_d[63:32] = busData;
              default: lanes_d[95:64] = busData;
            endcase
            beat_d = beat_q + 2'd1;
            oe_d   = 1'b1;
          end
        end else if (busOK == UMEM_OK_FAULT || (cnt_q + 8'd1) == TIMEOUT_LIM) begin
          state_d    = S_FAULT;
          ok_d       = UMEM_OK_FAULT;
          data_d     = '0;
          fill_fault = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          oe_d  = 1'b1;
        end
      end
      S_DONE: begin
        ok_d = UMEM_OK_OK;
        if (!memPcOE) begin
          state_d = S_IDLE;
          ok_d    = UMEM_OK_READY;
        end else if (req_tag != tag_q) begin
          tag_d   = req_tag;
          beat_d  = 2'd0;
          cnt_d   = 8'd0;
          state_d = S_FETCH;
          ok_d    = UMEM_OK_HOLD;
          oe_d    = 1'b1;
        end
      end
      default: begin
        ok_d = UMEM_OK_FAULT;
        if (!memPcOE) begin
          state_d = S_IDLE;
          ok_d    = UMEM_OK_READY;
        end
      end
    endcase
    addr_d = {tag_d, beat_d, 2'b00};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      lanes_q <= '0;
      data_q  <= '0;
      ok_q    <= UMEM_OK_READY;
      oe_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
    end
  end

  assign memPcData = data_q;
  assign memPcOK   = ok_q;
  assign busOE     = oe_q;
  assign busAddr   = addr_q;
endmodule

// File: tb/tb_ic_tile_mem_responder.sv
// tb/tb_ic_tile_mem_responder.sv - scoreboard bench for ic_tile_mem_responder.
`timescale 1ns/1ps
module tb_ic_tile_mem_responder;
  localparam logic [1:0] RDY = 2'd0;
  localparam logic [1:0] HLD = 2'd1;
  localparam logic [1:0] OKC = 2'd2;
  localparam logic [1:0] FLT = 2'd3;

  logic         clock = 1'b0;
  logic         reset;
  logic [63:0]  memPcAddr;
  logic         memPcOE;
  logic [127:0] memPcData;
  logic [1:0]   memPcOK;
  logic [31:0]  busAddr;
  logic         busOE;
  logic [31:0]  busData;
  logic [1:0]   busOK;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  bus_log[$];
  int           hold_left = 0;
  logic [1:0]   hold_beat = 2'd0;
  logic         fault_armed = 1'b0;
  logic [1:0]   fault_beat = 2'd0;

  always #5 clock = ~clock;

  ic_tile_mem_responder dut (
    .clock(clock), .reset(reset),
    .memPcAddr(memPcAddr), .memPcOE(memPcOE),
    .memPcData(memPcData), .memPcOK(memPcOK),
    .busAddr(busAddr), .busOE(busOE),
    .busData(busData), .busOK(busOK)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[15:0] ^ 16'hC3A5};
  endfunction

  function automatic logic [127:0] tile_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  // One cycle: sample at the falling edge, then drive the bus model's response.
  task automatic step();
    @(negedge clock);
    if (busOE) begin
      bus_log.push_back(busAddr);
      if (hold_left > 0 && busAddr[3:2] == hold_beat) begin
        busOK = HLD;
        busData = 32'hDEAD_BEEF;
        hold_left--;
      end else if (fault_armed && busAddr[3:2] == fault_beat) begin
        busOK = FLT;
        busData = 32'hBAD0_BAD0;
      end else begin
        busOK = OKC;
        busData = mem_word(busAddr);
      end
    end else begin
      busOK = RDY;
      busData = '0;
    end
  endtask

  task automatic request(input logic [31:0] addr, input int budget, output int cycles, output logic [1:0] fin);
    logic [127:0] d0;
    logic         changed;
    d0 = memPcData;
    changed = 1'b0;
    memPcAddr = {32'hFFFF_0000, addr};
    memPcOE = 1'b1;
    cycles = 0;
    fin = HLD;
    while (cycles < budget) begin
      step();
      cycles++;
      if (memPcOK !== HLD) break;
      if (memPcData !== d0) changed = 1'b1;
    end
    fin = memPcOK;
    checks++;
    if (changed) begin
      errors++;
      $display("FAIL data_stable_while_hold addr=%h: memPcData changed before completion", addr);
    end
    if (fin === OKC) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty addr=%h: got %h, no tile expected", addr, memPcData);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (memPcData !== e) begin
          errors++;
          $display("FAIL tile_data addr=%h: got %h expected %h", addr, memPcData, e);
        end
      end
    end
  endtask

  task automatic release_oe();
    memPcOE = 1'b0;
    step();
    checks++;
    if (memPcOK !== RDY || busOE !== 1'b0) begin
      errors++;
      $display("FAIL release_ready: ok=%0d busOE=%0b expected ok=%0d busOE=0", memPcOK, busOE, RDY);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memPcOE = 1'b0;
    memPcAddr = '0;
    busOK = RDY;
    busData = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (memPcOK !== RDY) begin errors++; $display("FAIL reset_ok: got %0d expected %0d", memPcOK, RDY); end
    checks++;
    if (memPcData !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", memPcData); end
    checks++;
    if (busOE !== 1'b0) begin errors++; $display("FAIL reset_busoe: got %0b expected 0", busOE); end
    checks++;
    if (busAddr !== 32'h0) begin errors++; $display("FAIL reset_busaddr: got %h expected 0", busAddr); end
    reset = 1'b0;
    step();
    checks++;
    if (memPcOK !== RDY) begin errors++; $display("FAIL idle_ok: got %0d expected %0d", memPcOK, RDY); end
  endtask

  task automatic test_basic();
    int cyc;
    logic [1:0] fin;
    bus_log.delete();
    exp_q.push_back(tile_of(32'h1230));
    request(32'h1230, 20, cyc, fin);
    checks++;
    if (fin !== OKC) begin errors++; $display("FAIL basic_ok: got %0d expected %0d", fin, OKC); end
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", cyc); end
    checks++;
    if (bus_log.size() != 4) begin
      errors++;
      $display("FAIL basic_beats: got %0d expected 4", bus_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bus_log[i] !== 32'h1230 + 32'(4 * i)) begin
          errors++;
          $display("FAIL basic_busaddr[%0d]: got %h expected %h", i, bus_log[i], 32'h1230 + 32'(4 * i));
        end
      end
    end
    step();
    checks++;
    if (memPcOK !== OKC || memPcData !== tile_of(32'h1230) || busOE !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: ok=%0d data=%h busOE=%0b", memPcOK, memPcData, busOE);
    end
    release_oe();
  endtask

  task automatic test_hold();
    int cyc;
    int n;
    logic [1:0] fin;
    bus_log.delete();
    hold_beat = 2'd2;
    hold_left = 3;
    exp_q.push_back(tile_of(32'h2230));
    request(32'h2230, 30, cyc, fin);
    n = 0;
    foreach (bus_log[i]) if (bus_log[i] == 32'h2238) n++;
    checks++;
    if (fin !== OKC) begin errors++; $display("FAIL hold_ok: got %0d expected %0d", fin, OKC); end
    checks++;
    if (cyc != 8) begin errors++; $display("FAIL hold_latency: got %0d expected 8", cyc); end
    checks++;
    if (n != 4) begin errors++; $display("FAIL hold_addr_cycles: got %0d expected 4", n); end
    release_oe();
  endtask

  task automatic test_timeout();
    int cyc;
    logic [1:0] fin;
    hold_beat = 2'd0;
    hold_left = 100000;
    request(32'h3230, 400, cyc, fin);
    checks++;
    if (fin !== FLT) begin errors++; $display("FAIL timeout_fault: got %0d expected %0d", fin, FLT); end
    checks++;
    if (cyc != 256) begin errors++; $display("FAIL timeout_latency: got %0d expected 256", cyc); end
    checks++;
    if (busOE !== 1'b0 || memPcData !== '0) begin
      errors++;
      $display("FAIL timeout_outputs: busOE=%0b data=%h expected 0/0", busOE, memPcData);
    end
    hold_left = 0;
    step();
    checks++;
    if (memPcOK !== FLT) begin errors++; $display("FAIL fault_held: got %0d expected %0d", memPcOK, FLT); end
    release_oe();
  endtask

  task automatic test_bus_fault();
    int cyc;
    logic [1:0] fin;
    fault_beat = 2'd1;
    fault_armed = 1'b1;
    request(32'h5230, 20, cyc, fin);
    checks++;
    if (fin !== FLT || cyc != 3) begin
      errors++;
      $display("FAIL busfault: ok=%0d cycles=%0d expected ok=%0d cycles=3", fin, cyc, FLT);
    end
    checks++;
    if (memPcData !== '0) begin errors++; $display("FAIL busfault_data: got %h expected 0", memPcData); end
    fault_armed = 1'b0;
    release_oe();
    bus_log.delete();
    exp_q.push_back(tile_of(32'h5230));
    request(32'h5230, 20, cyc, fin);
    checks++;
    if (fin !== OKC || cyc != 5 || bus_log.size() != 4) begin
      errors++;
      $display("FAIL refetch_after_fault: ok=%0d cycles=%0d beats=%0d expected %0d/5/4", fin, cyc, bus_log.size(), OKC);
    end
    release_oe();
  endtask

  task automatic test_retag();
    int cyc;
    logic [1:0] fin;
    exp_q.push_back(tile_of(32'h6230));
    request(32'h6230, 20, cyc, fin);
    bus_log.delete();
    exp_q.push_back(tile_of(32'h4560));
    request(32'h4560, 20, cyc, fin);
    checks++;
    if (fin !== OKC || cyc != 5) begin
      errors++;
      $display("FAIL retag: ok=%0d cycles=%0d expected %0d/5", fin, cyc, OKC);
    end
    checks++;
    if (bus_log.size() != 4 || bus_log[0] !== 32'h4560 || bus_log[3] !== 32'h456C) begin
      errors++;
      $display("FAIL retag_busaddr: beats=%0d first=%h expected 4 beats 4560..456c", bus_log.size(), bus_log[0]);
    end
  endtask

  task automatic test_tile_buffer();
    int cyc;
    logic [1:0] fin;
    release_oe();
    bus_log.delete();
    exp_q.push_back(tile_of(32'h4560));
    request(32'h4560, 20, cyc, fin);
    checks++;
`ifdef IC_RESP_TILE_BUF_EN
    if (fin !== OKC || cyc != 1 || bus_log.size() != 0) begin
      errors++;
      $display("FAIL buffer_hit: ok=%0d cycles=%0d beats=%0d expected %0d/1/0", fin, cyc, bus_log.size(), OKC);
    end
`else
    if (fin !== OKC || cyc != 5 || bus_log.size() != 4) begin
      errors++;
      $display("FAIL repeat_fetch: ok=%0d cycles=%0d beats=%0d expected %0d/5/4", fin, cyc, bus_log.size(), OKC);
    end
`endif
    release_oe();
  endtask

  task automatic test_oe_drop();
    logic [127:0] d0;
    d0 = memPcData;
    memPcAddr = 64'h7230;
    memPcOE = 1'b1;
    repeat (3) step();
    memPcOE = 1'b0;
    step();
    checks++;
    if (memPcOK !== RDY || busOE !== 1'b0 || memPcData !== d0) begin
      errors++;
      $display("FAIL oe_drop: ok=%0d busOE=%0b data=%h expected %0d/0/%h", memPcOK, busOE, memPcData, RDY, d0);
    end
    step();
    checks++;
    if (memPcOK !== RDY) begin errors++; $display("FAIL oe_drop_idle: got %0d expected %0d", memPcOK, RDY); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [1:0] fin;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'h8000_0000 | ($urandom & 32'h0FFF_FF00) | 32'(i * 16);
      exp_q.push_back(tile_of(a));
      request(a, 20, cyc, fin);
      checks++;
      if (fin !== OKC || cyc != 5) begin
        errors++;
        $display("FAIL back_to_back[%0d] addr=%h: ok=%0d cycles=%0d expected %0d/5", i, a, fin, cyc, OKC);
      end
    end
    release_oe();
  endtask

  task automatic test_reset_mid_fetch();
    memPcAddr = 64'h9230;
    memPcOE = 1'b1;
    repeat (2) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busOE !== 1'b0 || memPcOK !== RDY || memPcData !== '0) begin
      errors++;
      $display("FAIL async_reset: busOE=%0b ok=%0d data=%h expected 0/%0d/0", busOE, memPcOK, memPcData, RDY);
    end
    @(negedge clock);
    reset = 1'b0;
    memPcOE = 1'b0;
    step();
    checks++;
    if (memPcOK !== RDY || busAddr !== 32'h0) begin
      errors++;
      $display("FAIL after_reset: ok=%0d busAddr=%h expected %0d/0", memPcOK, busAddr, RDY);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_timeout();
    test_bus_fault();
    test_retag();
    test_tile_buffer();
    test_oe_drop();
    test_back_to_back();
    test_reset_mid_fetch();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d tiles never returned", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
